mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; only 32 is verified.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to issue op with operands a/b this cycle.
REQ-005 op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 no-op.
REQ-006 a  input  32  rs operand (register-file read port a).
REQ-007 b  input  32  rt operand (register-file read port b).
REQ-008 cancel  input  1  pipeline flush; aborts the in-flight op.
REQ-009 busy  output  1  op in flight; the pipeline stalls MFHI/MFLO/MDU ops while high.
REQ-010 done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV.
REQ-011 hi  output  32  HI register.
REQ-012 lo  output  32  LO register.

Function
REQ-013 FSM states IDLE, RUN, FIX; reset state IDLE; busy = (state != IDLE).
REQ-014 Accept: start=1, cancel=0, busy=0 at an edge; otherwise start is ignored.
REQ-015 MTHI/MTLO accepted: hi (or lo) <= a at that edge; the FSM stays in IDLE; done stays 0.
REQ-016 MULT/MULTU/DIV/DIVU accepted: latch operand magnitudes and sign flags, clear iteration counter, go to RUN.
REQ-017 RUN: one radix-2 step per cycle for 32 cycles; MULT uses shift-add, DIV uses restoring subtract.
REQ-018 RUN -> FIX after the 32nd step; FIX applies sign correction and writes hi/lo, then goes to IDLE.
REQ-019 Latency: accept at edge E0; busy=1 from after E0 to after E33; hi/lo update at E33; done=1 for exactly the cycle after E33.
REQ-020 Signed ops use absolute values; unsigned ops use raw values.
REQ-021 Product sign = sign(a) XOR sign(b); {hi,lo} = signed or unsigned 64-bit product, exact.
REQ-022 Divide: lo = quotient, truncated toward zero; hi = remainder with the sign of a.
REQ-023 Divide by zero: the algorithm runs unchanged. Unsigned: lo=0xFFFFFFFF, hi=a. Signed: lo=0xFFFFFFFF if a>=0 else 0x00000001, hi=a.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000; no trap.
REQ-025 cancel=1 in RUN or FIX: return to IDLE at that edge; hi/lo unchanged; no done pulse.
REQ-026 cancel=1 with start=1 in IDLE: cancel wins and the op is discarded, including MTHI/MTLO.
REQ-027 hi/lo change only per REQ-015 and REQ-018; they hold their values at all other times.
REQ-028 a/b may change after the accept edge without affecting the result.

Reset
REQ-029 resetn=0 asynchronously forces: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
REQ-030 Reset asserted mid-operation aborts the op.
REQ-031 The first accept after reset release is possible at the first rising edge with resetn=1.

Structure
REQ-032 Package mdu_pkg holds the op encodings, FSM state encoding and ITER=32 constant.
REQ-033 One sub-module, mdu_core: per-step shift-add/restoring-subtract datapath (combinational).
REQ-034 mdu owns the FSM, counter, sign handling and the HI/LO registers.

Verification
REQ-035 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 34 cycles hi=0xFFFFFFFE, lo=0x00000001, done one cycle.
REQ-036 MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-037 DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-038 MTHI a=0x12345678 while idle -> hi=0x12345678 next cycle, busy=0; repeat while busy -> hi unchanged.
REQ-039 DIVU started, cancel at cycle 10 -> busy=0 next cycle, hi/lo at previous values, no done; a new start is then accepted.
REQ-040 resetn pulsed low at cycle 5 of MULT -> busy, done, hi, lo all 0 immediately; a subsequent MULT 3*4 gives lo=12, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the iteration count of the radix-2 datapath.
package mdu_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_core.sv
// One radix-2 step: shift-add for multiply, restoring subtract for divide.
// acc holds the partial product high half / partial remainder; work holds
// the multiplier / dividend, which is shifted out as result bits shift in.
module mdu_core #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] work,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] work_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    sum       = {1'b0, acc} + (work[0] ? {1'b0, operand} : '0);
    rem_sh    = {acc, work[WIDTH-1]};
    borrow    = rem_sh < {1'b0, operand};
    // When no borrow the true difference is below the divisor, so the
    // truncated subtraction is exact; a zero divisor simply shifts a through.
    diff      = rem_sh[WIDTH-1:0] - operand;
    acc_next  = sum[WIDTH:1];
    work_next = {sum[0], work[WIDTH-1:1]};
    if (is_div) begin
      acc_next  = borrow ? rem_sh[WIDTH-1:0] : diff;
      work_next = {work[WIDTH-2:0], ~borrow};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative MIPS-style multiply/divide unit owning HI/LO. Operands are
// reduced to magnitudes at accept; signs are reapplied in the FIX state.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   acc_reg, work_reg, opnd_reg, hi_reg, lo_reg;
  logic               is_div_reg, neg_q_reg, neg_a_reg, done_reg;

  logic               accept, is_muldiv, is_signed, op_div, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b, acc_step, work_step, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;

  assign accept    = start && !cancel && (state_reg == S_IDLE);
  assign is_muldiv = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign sign_a    = is_signed && a[WIDTH-1];
  assign sign_b    = is_signed && b[WIDTH-1];
  assign mag_a     = sign_a ? -a : a;
  assign mag_b     = sign_b ? -b : b;

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .is_div    (is_div_reg),
    .acc       (acc_reg),
    .work      (work_reg),
    .operand   (opnd_reg),
    .acc_next  (acc_step),
    .work_next (work_step)
  );

  // Remainder takes the sign of the dividend; quotient/product take sa^sb.
  always_comb begin
    prod_raw = {acc_reg, work_reg};
    prod_fix = neg_q_reg ? -prod_raw : prod_raw;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      fix_hi = neg_a_reg ? -acc_reg : acc_reg;
      fix_lo = neg_q_reg ? -work_reg : work_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept && is_muldiv) state_next = S_RUN;
      S_RUN:   if (cancel) state_next = S_IDLE;
               else if (cnt_reg == CNT_W'(ITER - 1)) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      work_reg   <= '0;
      opnd_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_a_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept && op == OP_MTHI) hi_reg <= a;
      if (accept && op == OP_MTLO) lo_reg <= a;
      if (accept && is_muldiv) begin
        cnt_reg    <= '0;
        acc_reg    <= '0;
        work_reg   <= mag_a;
        opnd_reg   <= mag_b;
        is_div_reg <= op_div;
        neg_q_reg  <= sign_a ^ sign_b;
        neg_a_reg  <= sign_a;
      end
      if (state_reg == S_RUN && !cancel) begin
        acc_reg  <= acc_step;
        work_reg <= work_step;
        cnt_reg  <= cnt_reg + CNT_W'(1);
      end
      if (state_reg == S_FIX && !cancel) begin
        hi_reg   <= fix_hi;
        lo_reg   <= fix_lo;
        done_reg <= 1'b1;
      end
    end
  end

  assign busy = (state_reg != S_IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
